xpb_seq_accum: RTL



---
 rtl/xpb_pkg.sv | 23 ++
 rtl/xpb_acc_adder.sv | 46 ++++
 rtl/xpb_seq_accum.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb sequencing accumulator.
//   - default geometry of the xpb lookup (index width, positions, word width)
//   - FSM state encoding
//   - helper giving the accumulator width that cannot overflow
package xpb_pkg;

    localparam int XPB_SEG_BITS  = 5;
    localparam int XPB_NUM_SEGS  = 8;
    localparam int XPB_WORD_BITS = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } xpb_state_e;

    // Summing num_segs words of word_bits each needs clog2(num_segs) extra bits.
    function automatic int xpb_acc_bits(input int word_bits, input int num_segs);
        return word_bits + $clog2(num_segs);
    endfunction

endpackage

// File: rtl/xpb_acc_adder.sv
// Registered accumulator for xpb residues.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : load zero into the accumulator (has priority over add_en)
//   add_en     : load acc + addend into the accumulator
//   addend     : WORD_BITS unsigned term, zero-extended to ACC_BITS
//   sum        : combinational acc + addend, used by the caller to capture the
//                final total in the same cycle as the last term arrives
module xpb_acc_adder
    import xpb_pkg::*;
#(
    parameter int WORD_BITS = XPB_WORD_BITS,
    parameter int ACC_BITS  = xpb_acc_bits(XPB_WORD_BITS, XPB_NUM_SEGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 add_en,
    input  logic [WORD_BITS-1:0] addend,
    output logic [ACC_BITS-1:0]  sum
);

    logic [ACC_BITS-1:0] acc_q;
    logic [ACC_BITS-1:0] acc_d;

    always_comb begin
        sum = acc_q + {{(ACC_BITS-WORD_BITS){1'b0}}, addend};
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/xpb_seq_accum.sv
// Sequencing accumulator downstream of the per-position xpb lookup tables.
// Captures NUM_SEGS packed indices, issues one (index, position) pair per
// cycle to the registered lookup, sums the returned residues and presents
// the total over a valid/ready handshake.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake; in_ready is high only when idle
//   seg_in               packed indices, segment k = [k*SEG_BITS +: SEG_BITS]
//   lut_idx / lut_sel    registered index and table position
//   lut_data             table word, valid the cycle after lut_idx/lut_sel
//   out_valid/out_ready  output handshake
//   sum_out              accumulated total, held stable while out_valid
//
// Build option: XPB_ACC_ZERO_SKIP_EN -- when defined, zero indices are not
// issued; latency becomes (nonzero count)+2. Undefined: every segment is
// issued and latency is fixed at NUM_SEGS+2.
module xpb_seq_accum
    import xpb_pkg::*;
#(
    parameter int SEG_BITS  = XPB_SEG_BITS,
    parameter int NUM_SEGS  = XPB_NUM_SEGS,
    parameter int WORD_BITS = XPB_WORD_BITS,
    parameter int ACC_BITS  = xpb_acc_bits(WORD_BITS, NUM_SEGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEG_BITS*NUM_SEGS-1:0]  seg_in,
    output logic [SEG_BITS-1:0]           lut_idx,
    output logic [$clog2(NUM_SEGS)-1:0]   lut_sel,
    input  logic [WORD_BITS-1:0]          lut_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_BITS-1:0]           sum_out
);

    localparam int SEL_BITS = $clog2(NUM_SEGS);
    localparam int IN_W     = SEG_BITS * NUM_SEGS;

    // Lowest set bit of mask at position >= from, returned as {found, pos}.
    function automatic logic [SEL_BITS:0] next_pos(input logic [NUM_SEGS-1:0] mask,
                                                   input int                  from);
        logic [SEL_BITS:0] r;
        r = '0;
        for (int i = NUM_SEGS - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                r = {1'b1, SEL_BITS'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [SEG_BITS-1:0] seg_at(input logic [IN_W-1:0]     s,
                                                   input logic [SEL_BITS-1:0] k);
        return s[int'(k)*SEG_BITS +: SEG_BITS];
    endfunction

    xpb_state_e             state_q, state_d;
    logic [SEL_BITS-1:0]    k_q, k_d;
    logic [IN_W-1:0]        seg_q, seg_d;
    logic [NUM_SEGS-1:0]    mask_q, mask_d;
    logic [SEG_BITS-1:0]    lut_idx_q, lut_idx_d;
    logic [SEL_BITS-1:0]    lut_sel_q, lut_sel_d;
    logic                   iss_q, iss_d;     // lut_idx_q carries a real issue
    logic                   pend_q, pend_d;   // lut_data this cycle belongs to an issue
    logic                   out_valid_q, out_valid_d;
    logic [ACC_BITS-1:0]    sum_out_q, sum_out_d;

    logic [NUM_SEGS-1:0]    cap_mask;
    logic [SEL_BITS:0]      first_pos;
    logic [SEL_BITS:0]      nxt_pos;
    logic                   acc_clr;
    logic                   acc_add;
    logic [WORD_BITS-1:0]   addend;
    logic [ACC_BITS-1:0]    acc_sum;

    // Positions that will be issued for the operation being accepted.
`ifdef XPB_ACC_ZERO_SKIP_EN
    always_comb begin
        cap_mask = '0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            cap_mask[i] = |seg_in[i*SEG_BITS +: SEG_BITS];
        end
    end
`else
    always_comb begin
        cap_mask = '1;
    end
`endif

    // Only table words that answer a real issue enter the sum.
    always_comb begin
        addend = pend_q ? lut_data : '0;
    end

    xpb_acc_adder #(
        .WORD_BITS (WORD_BITS),
        .ACC_BITS  (ACC_BITS)
    ) u_adder (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .add_en (acc_add),
        .addend (addend),
        .sum    (acc_sum)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        seg_d       = seg_q;
        mask_d      = mask_q;
        lut_idx_d   = '0;
        lut_sel_d   = '0;
        iss_d       = 1'b0;
        pend_d      = iss_q;
        out_valid_d = out_valid_q;
        sum_out_d   = sum_out_q;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;
        first_pos   = next_pos(cap_mask, 0);
        nxt_pos     = next_pos(mask_q, int'(k_q) + 1);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    seg_d   = seg_in;
                    mask_d  = cap_mask;
                    acc_clr = 1'b1;
                    // The first index goes out on the accept edge so the
                    // table answers while ISSUE walks the remaining ones.
                    if (first_pos[SEL_BITS]) begin
                        k_d       = first_pos[SEL_BITS-1:0];
                        lut_idx_d = seg_at(seg_in, first_pos[SEL_BITS-1:0]);
                        lut_sel_d = first_pos[SEL_BITS-1:0];
                        iss_d     = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_ISSUE: begin
                acc_add = 1'b1;
                if (nxt_pos[SEL_BITS]) begin
                    k_d       = nxt_pos[SEL_BITS-1:0];
                    lut_idx_d = seg_at(seg_q, nxt_pos[SEL_BITS-1:0]);
                    lut_sel_d = nxt_pos[SEL_BITS-1:0];
                    iss_d     = 1'b1;
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Final table word is folded straight into the output register.
                sum_out_d   = acc_sum;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            seg_q       <= '0;
            mask_q      <= '0;
            lut_idx_q   <= '0;
            lut_sel_q   <= '0;
            iss_q       <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sum_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            seg_q       <= seg_d;
            mask_q      <= mask_d;
            lut_idx_q   <= lut_idx_d;
            lut_sel_q   <= lut_sel_d;
            iss_q       <= iss_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            sum_out_q   <= sum_out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign lut_idx   = lut_idx_q;
    assign lut_sel   = lut_sel_q;
    assign out_valid = out_valid_q;
    assign sum_out   = sum_out_q;

endmodule
